// File: rtl/cpu_pkg.sv
// Shared definitions for the 8-bit accumulator CPU control unit.
//
// Contents:
//   - instruction opcodes (high nibble of the instruction word)
//   - FSM state encoding (ESPERA exists only when SINGLE_STEP_EN is defined)
//   - ALU operation and A-source select encodings
//   - control bundle produced by the decoder and registered in DECODIFICA
//
// Optional feature macro: SINGLE_STEP_EN (adds the ESPERA state).
package cpu_pkg;

    localparam int OPCODE_W = 4;

    localparam logic [OPCODE_W-1:0] OP_ADD = 4'h0;
    localparam logic [OPCODE_W-1:0] OP_SUB = 4'h1;
    localparam logic [OPCODE_W-1:0] OP_LDA = 4'h2;
    localparam logic [OPCODE_W-1:0] OP_STA = 4'h3;
    localparam logic [OPCODE_W-1:0] OP_LDB = 4'h4;
    localparam logic [OPCODE_W-1:0] OP_STB = 4'h5;
    localparam logic [OPCODE_W-1:0] OP_LDC = 4'h6;
    localparam logic [OPCODE_W-1:0] OP_JMP = 4'h7;
    localparam logic [OPCODE_W-1:0] OP_AND = 4'h8;
    localparam logic [OPCODE_W-1:0] OP_OR  = 4'h9;
    localparam logic [OPCODE_W-1:0] OP_BEQ = 4'hA;
    localparam logic [OPCODE_W-1:0] OP_HLT = 4'hF;

    typedef enum logic [2:0] {
        BUSCA      = 3'd0,
        DECODIFICA = 3'd1,
        EXECUTA    = 3'd2,
        LEITURA    = 3'd3,
        ESCRITA    = 3'd4,
        PARADO     = 3'd5
`ifdef SINGLE_STEP_EN
        ,
        ESPERA     = 3'd6
`endif
    } estado_t;

    typedef enum logic [1:0] {
        ALU_ADD = 2'b00,
        ALU_SUB = 2'b01,
        ALU_AND = 2'b10,
        ALU_OR  = 2'b11
    } alu_op_t;

    typedef enum logic [1:0] {
        FONTE_ALU  = 2'b00,
        FONTE_RAM  = 2'b01,
        FONTE_IMED = 2'b10
    } fonte_a_t;

    // Where DECODIFICA sends the FSM next.
    typedef enum logic [1:0] {
        CLASSE_EXEC = 2'd0,
        CLASSE_LEIT = 2'd1,
        CLASSE_PARA = 2'd2
    } classe_t;

    typedef struct packed {
        logic     carrega_a;     // A written in EXECUTA (ALU ops, LDC)
        fonte_a_t sel_fonte_a;
        alu_op_t  alu_op;
        logic     ram_escreve;   // STA/STB
        logic     sel_dado_ram;  // 1 selects B as RAM write data
        logic     destino_b;     // LDB: ESCRITA loads B instead of A
        logic     salto_jmp;
        logic     salto_beq;
    } controle_t;

endpackage

// File: rtl/unidade_controle_decodificador.sv
// decodificador: purely combinational instruction decoder.
//
// Ports:
//   opcode   in   4   instruction high nibble
//   controle out  -   control bundle for EXECUTA/ESCRITA
//   classe   out  2   next-state class taken from DECODIFICA
//
// Opcodes 1011..1110 decode as NOP (empty bundle, EXECUTA class).
module decodificador
    import cpu_pkg::*;
(
    input  logic [OPCODE_W-1:0] opcode,
    output controle_t           controle,
    output classe_t             classe
);

    always_comb begin
        controle = '0;
        classe   = CLASSE_EXEC;
        case (opcode)
            OP_ADD: begin
                controle.carrega_a = 1'b1;
                controle.alu_op    = ALU_ADD;
            end
            OP_SUB: begin
                controle.carrega_a = 1'b1;
                controle.alu_op    = ALU_SUB;
            end
            OP_AND: begin
                controle.carrega_a = 1'b1;
                controle.alu_op    = ALU_AND;
            end
            OP_OR: begin
                controle.carrega_a = 1'b1;
                controle.alu_op    = ALU_OR;
            end
            OP_LDC: begin
                controle.carrega_a   = 1'b1;
                controle.sel_fonte_a = FONTE_IMED;
            end
            OP_STA: controle.ram_escreve = 1'b1;
            OP_STB: begin
                controle.ram_escreve  = 1'b1;
                controle.sel_dado_ram = 1'b1;
            end
            OP_LDA: classe = CLASSE_LEIT;
            OP_LDB: begin
                classe             = CLASSE_LEIT;
                controle.destino_b = 1'b1;
            end
            OP_JMP: controle.salto_jmp = 1'b1;
            OP_BEQ: controle.salto_beq = 1'b1;
            OP_HLT: classe = CLASSE_PARA;
            default: ;
        endcase
    end

endmodule

// File: rtl/unidade_controle.sv
// unidade_controle: fetch/decode/execute sequencer of the accumulator CPU.
// Owns PC and IR, addresses the combinational instruction ROM and issues
// one-cycle strobes to the A/B registers, ALU and 16-word data RAM.
//
// Ports:
//   clk, rst_n          clock; synchronous active-low reset
//   passo               single-step advance (only with SINGLE_STEP_EN)
//   pc_out              ROM address
//   instrucao_in        ROM data
//   a_zero, b_zero,
//   a_igual_b           datapath flags for JMP / BEQ
//   imediato, ram_end   zero-extended operand / RAM address
//   ram_le, ram_escreve RAM read / write strobes
//   sel_fonte_a         A source: 00 ALU, 01 RAM, 10 imediato
//   sel_dado_ram        RAM write data: 0 A, 1 B
//   alu_op              00 ADD, 01 SUB, 10 AND, 11 OR
//   carrega_a/carrega_b register write enables
//   parado              high after HLT until reset
//
// Optional feature macro: SINGLE_STEP_EN (adds passo and state ESPERA).
module unidade_controle
    import cpu_pkg::*;
#(
    parameter int PC_W   = 8,
    parameter int DADO_W = 8,
    parameter int OPR_W  = 4
) (
    input  logic              clk,
    input  logic              rst_n,
`ifdef SINGLE_STEP_EN
    input  logic              passo,
`endif
    output logic [PC_W-1:0]   pc_out,
    input  logic [DADO_W-1:0] instrucao_in,
    input  logic              a_zero,
    input  logic              b_zero,
    input  logic              a_igual_b,
    output logic [DADO_W-1:0] imediato,
    output logic [OPR_W-1:0]  ram_end,
    output logic              ram_le,
    output logic              ram_escreve,
    output logic [1:0]        sel_fonte_a,
    output logic              sel_dado_ram,
    output logic [1:0]        alu_op,
    output logic              carrega_a,
    output logic              carrega_b,
    output logic              parado
);

    // State entered after reset and after every completed instruction.
`ifdef SINGLE_STEP_EN
    localparam estado_t ESTADO_REPOUSO = ESPERA;
`else
    localparam estado_t ESTADO_REPOUSO = BUSCA;
`endif

    estado_t           estado_reg, estado_next;
    logic [PC_W-1:0]   pc_reg, pc_next;
    logic [DADO_W-1:0] ir_reg, ir_next;
    controle_t         ctrl_reg, ctrl_next;

    controle_t         ctrl_dec;
    classe_t           classe_dec;
    logic [OPR_W-1:0]  operando;

    // IR is loaded at the end of BUSCA, so the operand is stable from
    // DECODIFICA until the next fetch overwrites IR.
    assign operando = ir_reg[OPR_W-1:0];
    assign imediato = {{(DADO_W-OPR_W){1'b0}}, operando};
    assign ram_end  = operando;
    assign pc_out   = pc_reg;

    decodificador u_decodificador (
        .opcode   (ir_reg[DADO_W-1 -: OPCODE_W]),
        .controle (ctrl_dec),
        .classe   (classe_dec)
    );

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            estado_reg <= ESTADO_REPOUSO;
            pc_reg     <= '0;
            ir_reg     <= '0;
            ctrl_reg   <= '0;
        end else begin
            estado_reg <= estado_next;
            pc_reg     <= pc_next;
            ir_reg     <= ir_next;
            ctrl_reg   <= ctrl_next;
        end
    end

    always_comb begin
        estado_next  = estado_reg;
        pc_next      = pc_reg;
        ir_next      = ir_reg;
        ctrl_next    = ctrl_reg;
        ram_le       = 1'b0;
        ram_escreve  = 1'b0;
        sel_fonte_a  = FONTE_ALU;
        sel_dado_ram = 1'b0;
        alu_op       = ALU_ADD;
        carrega_a    = 1'b0;
        carrega_b    = 1'b0;
        parado       = 1'b0;

        case (estado_reg)
`ifdef SINGLE_STEP_EN
            ESPERA: begin
                if (passo) estado_next = BUSCA;
            end
`endif
            BUSCA: begin
                ir_next     = instrucao_in;
                pc_next     = pc_reg + PC_W'(1);
                estado_next = DECODIFICA;
            end
            DECODIFICA: begin
                ctrl_next = ctrl_dec;
                case (classe_dec)
                    CLASSE_LEIT: estado_next = LEITURA;
                    CLASSE_PARA: estado_next = PARADO;
                    default:     estado_next = EXECUTA;
                endcase
            end
            EXECUTA: begin
                carrega_a    = ctrl_reg.carrega_a;
                sel_fonte_a  = ctrl_reg.sel_fonte_a;
                alu_op       = ctrl_reg.alu_op;
                ram_escreve  = ctrl_reg.ram_escreve;
                sel_dado_ram = ctrl_reg.sel_dado_ram;
                // Replaces the increment done during BUSCA.
                if ((ctrl_reg.salto_jmp && a_zero && b_zero) ||
                    (ctrl_reg.salto_beq && a_igual_b))
                    pc_next = {{(PC_W-OPR_W){1'b0}}, operando};
                estado_next = ESTADO_REPOUSO;
            end
            LEITURA: begin
                ram_le      = 1'b1;
                estado_next = ESCRITA;
            end
            ESCRITA: begin
                if (ctrl_reg.destino_b) begin
                    carrega_b = 1'b1;
                end else begin
                    carrega_a   = 1'b1;
                    sel_fonte_a = FONTE_RAM;
                end
                estado_next = ESTADO_REPOUSO;
            end
            PARADO: begin
                parado = 1'b1;
            end
            default: estado_next = ESTADO_REPOUSO;
        endcase
    end

endmodule

// File: tb/tb_unidade_controle.sv
// Scoreboard bench for unidade_controle. The stimulus process loads a model
// ROM, resets the DUT and pushes one expected-output record per clock cycle;
// the monitor pops one record at every falling edge and compares.
// Build with SINGLE_STEP_EN defined to exercise the passo/ESPERA variant.
module tb_unidade_controle;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [7:0] pc_out, instrucao_in, imediato;
    logic [3:0] ram_end;
    logic       ram_le, ram_escreve, sel_dado_ram, carrega_a, carrega_b, parado;
    logic [1:0] sel_fonte_a, alu_op;
    logic       a_zero, b_zero, a_igual_b;
`ifdef SINGLE_STEP_EN
    logic       passo;
`endif

    logic [7:0] rom [256];
    assign instrucao_in = rom[pc_out];

    always #5 clk = ~clk;

    unidade_controle dut (
        .clk          (clk),
        .rst_n        (rst_n),
`ifdef SINGLE_STEP_EN
        .passo        (passo),
`endif
        .pc_out       (pc_out),
        .instrucao_in (instrucao_in),
        .a_zero       (a_zero),
        .b_zero       (b_zero),
        .a_igual_b    (a_igual_b),
        .imediato     (imediato),
        .ram_end      (ram_end),
        .ram_le       (ram_le),
        .ram_escreve  (ram_escreve),
        .sel_fonte_a  (sel_fonte_a),
        .sel_dado_ram (sel_dado_ram),
        .alu_op       (alu_op),
        .carrega_a    (carrega_a),
        .carrega_b    (carrega_b),
        .parado       (parado)
    );

    // One record per clock cycle. chk_all: compare every output (cycle right
    // after reset, everything zero). chk_opr: operand fields are defined.
    typedef struct packed {
        logic [7:0] pc;
        logic       ca, cb, rle, resc;
        logic [1:0] sf;
        logic       sdr;
        logic [1:0] aop;
        logic [3:0] opr;
        logic       chk_opr;
        logic       parado;
        logic       chk_all;
    } exp_t;

    exp_t  q[$];
    int    n_pass  = 0;
    int    n_total = 0;
    int    n_ciclo = 0;
    string cur_test = "init";

    always @(negedge clk) begin : monitor
        exp_t e;
        bit   ok;
        if (q.size() > 0) begin
            e  = q.pop_front();
            ok = (pc_out == e.pc) && (carrega_a == e.ca) && (carrega_b == e.cb) &&
                 (ram_le == e.rle) && (ram_escreve == e.resc) && (parado == e.parado);
            if (e.chk_all || e.chk_opr)
                ok = ok && (imediato == {4'h0, e.opr}) && (ram_end == e.opr);
            if (e.chk_all || e.ca)
                ok = ok && (sel_fonte_a == e.sf);
            if (e.chk_all || (e.ca && e.sf == 2'b00))
                ok = ok && (alu_op == e.aop);
            if (e.chk_all || e.resc)
                ok = ok && (sel_dado_ram == e.sdr);
            n_total++;
            if (ok) n_pass++;
            else
                $display("FAIL %s cycle %0d: got pc=%02h ca=%b cb=%b le=%b wr=%b sf=%b aop=%b sdr=%b imed=%02h end=%h parado=%b; want pc=%02h ca=%b cb=%b le=%b wr=%b sf=%b aop=%b sdr=%b opr=%h parado=%b",
                         cur_test, n_ciclo, pc_out, carrega_a, carrega_b, ram_le, ram_escreve,
                         sel_fonte_a, alu_op, sel_dado_ram, imediato, ram_end, parado,
                         e.pc, e.ca, e.cb, e.rle, e.resc, e.sf, e.aop, e.sdr, e.opr, e.parado);
            n_ciclo++;
        end
    end

    task automatic rom_nops();
        for (int i = 0; i < 256; i++) rom[i] = 8'hB0;
    endtask

    // Called at posedge+1; returns at posedge+1 of the first cycle after reset.
    task automatic do_reset();
        rst_n = 1'b0;
        @(posedge clk);
        #1 rst_n = 1'b1;
        n_ciclo = 1;
    endtask

    task automatic push_idle(input logic [7:0] pc, input bit all, input int n);
        exp_t e;
        e         = '0;
        e.pc      = pc;
        e.chk_all = all;
        for (int i = 0; i < n; i++) q.push_back(e);
    endtask

    // Expected cycles of one instruction fetched from pc_f.
    task automatic exp_instr(input logic [7:0] pc_f, input logic [7:0] ins, input bit first);
        exp_t       e;
        bit         prim;
        logic [3:0] op;
        prim = first;
        op   = ins[7:4];
        $display("txn %s: fetch pc=%02h instr=%02h", cur_test, pc_f, ins);
`ifdef SINGLE_STEP_EN
        push_idle(pc_f, prim, 1);   // ESPERA
        prim = 1'b0;
`endif
        push_idle(pc_f, prim, 1);   // BUSCA
        e         = '0;             // DECODIFICA
        e.pc      = pc_f + 8'd1;
        e.opr     = ins[3:0];
        e.chk_opr = 1'b1;
        q.push_back(e);
        case (op)
            4'h0, 4'h1, 4'h8, 4'h9: begin
                e.ca = 1'b1;
                case (op)
                    4'h0:    e.aop = 2'b00;
                    4'h1:    e.aop = 2'b01;
                    4'h8:    e.aop = 2'b10;
                    default: e.aop = 2'b11;
                endcase
                q.push_back(e);
            end
            4'h6: begin e.ca = 1'b1; e.sf = 2'b10; q.push_back(e); end
            4'h3: begin e.resc = 1'b1; e.sdr = 1'b0; q.push_back(e); end
            4'h5: begin e.resc = 1'b1; e.sdr = 1'b1; q.push_back(e); end
            4'h2: begin
                e.rle = 1'b1; q.push_back(e);
                e.rle = 1'b0; e.ca = 1'b1; e.sf = 2'b01; q.push_back(e);
            end
            4'h4: begin
                e.rle = 1'b1; q.push_back(e);
                e.rle = 1'b0; e.cb = 1'b1; q.push_back(e);
            end
            4'hF: ;                 // PARADO cycles pushed by the caller
            default: q.push_back(e); // JMP/BEQ/NOP: EXECUTA without strobes
        endcase
    endtask

    task automatic drain();
        int g;
        g = 0;
        while (q.size() > 0 && g < 5000) begin
            @(posedge clk);
            g++;
        end
        if (q.size() > 0) begin
            n_total++;
            $display("FAIL %s timeout: %0d cycles left, want 0", cur_test, q.size());
            q.delete();
        end
        #1;
    endtask

    initial begin
        rst_n = 1'b1; a_zero = 1'b0; b_zero = 1'b0; a_igual_b = 1'b0;
`ifdef SINGLE_STEP_EN
        passo = 1'b1;
`endif
        rom_nops();

        cur_test = "ldc"; rom[0] = 8'h61;
        do_reset(); exp_instr(8'h00, 8'h61, 1); exp_instr(8'h01, 8'hB0, 0); drain();

        cur_test = "ldb"; rom[0] = 8'h47;
        do_reset(); exp_instr(8'h00, 8'h47, 1); exp_instr(8'h01, 8'hB0, 0); drain();

        cur_test = "jmp_taken"; rom[0] = 8'h7F; a_zero = 1'b1; b_zero = 1'b1;
        do_reset(); exp_instr(8'h00, 8'h7F, 1); exp_instr(8'h0F, 8'hB0, 0);
        exp_instr(8'h10, 8'hB0, 0); drain();

        cur_test = "jmp_b_nz"; b_zero = 1'b0;
        do_reset(); exp_instr(8'h00, 8'h7F, 1); exp_instr(8'h01, 8'hB0, 0); drain();

        cur_test = "jmp_a_nz"; a_zero = 1'b0; b_zero = 1'b1;
        do_reset(); exp_instr(8'h00, 8'h7F, 1); exp_instr(8'h01, 8'hB0, 0); drain();
        b_zero = 1'b0;

        cur_test = "beq_taken"; rom[0] = 8'hAC; a_igual_b = 1'b1;
        do_reset(); exp_instr(8'h00, 8'hAC, 1); exp_instr(8'h0C, 8'hB0, 0); drain();

        cur_test = "beq_not"; a_igual_b = 1'b0;
        do_reset(); exp_instr(8'h00, 8'hAC, 1); exp_instr(8'h01, 8'hB0, 0); drain();

        cur_test = "seq";
        rom[0] = 8'h03; rom[1] = 8'h15; rom[2] = 8'h82; rom[3] = 8'h91;
        rom[4] = 8'h35; rom[5] = 8'h52; rom[6] = 8'h24; rom[7] = 8'hC0;
        do_reset();
        for (int i = 0; i < 8; i++) exp_instr(8'(i), rom[i], i == 0);
        drain();

        cur_test = "wrap"; rom_nops();
        do_reset();
        for (int i = 0; i < 256; i++) exp_instr(8'(i), 8'hB0, i == 0);
        exp_instr(8'h00, 8'hB0, 0);
        drain();

        cur_test = "hlt"; rom[0] = 8'hF0;
        do_reset(); exp_instr(8'h00, 8'hF0, 1);
        begin
            exp_t e;
            e = '0; e.pc = 8'h01; e.parado = 1'b1;
            for (int i = 0; i < 12; i++) q.push_back(e);
        end
        drain();

        cur_test = "reset_mid_lda"; rom_nops(); rom[0] = 8'h23;
        do_reset();
        begin
            exp_t e;
`ifdef SINGLE_STEP_EN
            push_idle(8'h00, 1, 1);
`endif
            push_idle(8'h00, 0, 1);
            e = '0; e.pc = 8'h01; e.opr = 4'h3; e.chk_opr = 1'b1; q.push_back(e);
            e.rle = 1'b1; q.push_back(e);
        end
`ifdef SINGLE_STEP_EN
        repeat (3) @(posedge clk);
`else
        repeat (2) @(posedge clk);
`endif
        #1 rst_n = 1'b0;            // during LEITURA
        @(posedge clk);
        #1 rst_n = 1'b1;
        exp_instr(8'h00, 8'h23, 1); exp_instr(8'h01, 8'hB0, 0);
        drain();

`ifdef SINGLE_STEP_EN
        cur_test = "passo_gate"; rom_nops(); passo = 1'b0;
        do_reset();
        push_idle(8'h00, 1, 5);
        repeat (5) @(posedge clk);
        #1 passo = 1'b1;
        exp_instr(8'h00, 8'hB0, 0);
        push_idle(8'h01, 0, 6);
        @(posedge clk);
        #1 passo = 1'b0;
        drain();
        passo = 1'b1;
`endif

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

// File: doc/unidade_controle.md
Name: unidade_controle

Overview:
- Fetch/decode/execute sequencer for the 8-bit accumulator CPU.
- Owns the program counter and instruction register, and drives the instruction ROM address.
- Issues one-cycle control strobes to the external A/B register file, the ALU and the 16-word data RAM.
- Consumes status flags from the datapath to resolve the conditional JMP and BEQ.

Parameters:
- PC_W, 8, program counter / ROM address width.
- DADO_W, 8, instruction and data width.
- OPR_W, 4, operand field width (low nibble of the instruction).

Ports:
- clk  in  1  clock; all state changes on the rising edge.
- rst_n  in  1  synchronous reset, active-low.
- pc_out  out  PC_W  ROM address; connects to the ROM ler_endereco input (combinational ROM).
- instrucao_in  in  DADO_W  ROM data; connects to instrucao_out.
- a_zero  in  1  A == 0, from datapath.
- b_zero  in  1  B == 0, from datapath.
- a_igual_b  in  1  A == B, from datapath.
- imediato  out  DADO_W  zero-extended operand, used as the LDC source.
- ram_end  out  OPR_W  RAM address = operand.
- ram_le  out  1  RAM read strobe; data is valid the next cycle.
- ram_escreve  out  1  RAM write strobe.
- sel_fonte_a  out  2  A write source: 00 = ALU, 01 = RAM, 10 = imediato.
- sel_dado_ram  out  1  RAM write data: 0 = A, 1 = B.
- alu_op  out  2  00 ADD, 01 SUB, 10 AND, 11 OR.
- carrega_a  out  1  A write enable.
- carrega_b  out  1  B write enable; B is always loaded from RAM.
- parado  out  1  high once HLT has executed.

Behaviour:
- Reset (rst_n low at a rising edge):
  - PC = 0, IR = 0, state = BUSCA.
  - All strobes, parado, alu_op, sel_* and imediato = 0.
  - Reset takes effect from any state, including mid-instruction.
  - No strobe is asserted in the cycle after reset.
- Opcodes (IR[7:4]):
  - 0000 ADD, 0001 SUB, 0010 LDA, 0011 STA, 0100 LDB, 0101 STB, 0110 LDC, 0111 JMP, 1000 AND, 1001 OR, 1010 BEQ, 1111 HLT.
  - 1011–1110 are NOPs.
- States:
  - BUSCA: IR <= instrucao_in; PC <= PC+1 (wraps 255 -> 0). Next state DECODIFICA.
  - DECODIFICA: register the control bundle from the decoder. Next state is LEITURA for LDA/LDB, PARADO for HLT, otherwise EXECUTA.
  - EXECUTA: assert the strobes for one cycle.
    - ADD/SUB/AND/OR: carrega_a = 1, sel_fonte_a = 00, alu_op per opcode.
    - LDC: carrega_a = 1, sel_fonte_a = 10.
    - STA/STB: ram_escreve = 1, sel_dado_ram = 0 / 1.
    - JMP: if a_zero && b_zero then PC <= operand.
    - BEQ: if a_igual_b then PC <= operand.
    - The jump PC load overrides the increment already done in BUSCA. Flags are sampled in this cycle.
    - Next state BUSCA.
  - LEITURA: ram_le = 1. Next state ESCRITA.
  - ESCRITA: carrega_a = 1 with sel_fonte_a = 01 (LDA), or carrega_b = 1 (LDB). Next state BUSCA.
  - PARADO: parado = 1; no strobes; PC frozen. Exit only by reset.
- ram_end and imediato hold the current operand from DECODIFICA until the next BUSCA.
- Latency:
  - ALU ops, LDC, STA/STB, JMP/BEQ and NOP: 3 cycles.
  - LDA/LDB: 4 cycles.
  - HLT: parado rises 2 cycles after its BUSCA.
- Mutual exclusion: at most one of carrega_a, carrega_b, ram_escreve, ram_le is high in any cycle.
- Jump targets are zero-extended 4-bit operands, so only ROM 0–15 is reachable by a jump.

Optional Feature:
- SINGLE_STEP_EN defined:
  - Adds input port passo (1 bit) and state ESPERA.
  - After reset and after each completed instruction, the FSM waits in ESPERA; a high passo at a clock edge moves it to BUSCA.
  - passo held high steps continuously, with one idle ESPERA cycle per instruction.
  - passo is ignored in PARADO.
- Not defined: the passo port and the ESPERA state are absent; execution runs continuously.

Decomposition:
- Package cpu_pkg holds:
  - the opcode localparams;
  - the state encoding;
  - the alu_op and sel_fonte_a encodings;
  - the control-bundle struct.
- Sub-module decodificador: purely combinational, opcode -> control bundle plus next-state class. The FSM, PC and IR stay in unidade_controle.

Test Plan:
- Reset, then ROM[0] = 0x61 (LDC #1): pc_out = 0 then 1; carrega_a = 1 with sel_fonte_a = 10 and imediato = 0x01 exactly at cycle 3.
- ROM[0] = 0x47 (LDB #7): ram_le at cycle 3 with ram_end = 7; carrega_b at cycle 4; next fetch at pc = 1 in cycle 5.
- ROM[0] = 0x7F (JMP #15):
  - a_zero = b_zero = 1: next fetch address is 15.
  - b_zero = 0: next fetch address is 1.
- ROM[0] = 0xAC (BEQ #12) with a_igual_b = 1: next fetch address is 12. Repeat with a_igual_b = 0: next fetch address is 1.
- PC wrap: ROM filled with NOP (0xB0); after 256 instructions pc_out returns to 0. ROM[0] = 0xF0: parado = 1 and pc_out holds 1 indefinitely, with no strobes.
- Assert rst_n low during the LEITURA of an LDA: next cycle pc_out = 0, all strobes 0, and no carrega_a is issued. With SINGLE_STEP_EN defined: no fetch occurs until passo pulses.
